// File: rtl/ps2_game_input_if.sv
// PS/2 pin and game-control bundle between the board pins, the PS/2 decoder
// and the game FSM.
interface ps2_game_input_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       startGame;
  logic [2:0] userGameInput;
  logic       key_valid;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_dat,
    input  startGame, userGameInput, key_valid, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output startGame, userGameInput, key_valid, frame_error
  );
endinterface

// File: rtl/ps2_game_input.sv
// PS/2 scan-code set 2 receiver feeding the game FSM: frame reception with
// parity/stop/timeout checks, then break/extended/typematic-aware key decoding.
module ps2_game_input #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic        clock,
  input logic        reset,
  ps2_game_input_if.slave bus
);

  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_DATA   = 2'd1;
  localparam logic [1:0] R_PARITY = 2'd2;
  localparam logic [1:0] R_STOP   = 2'd3;

  localparam int          CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_ONE = CW'(1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity;
  logic [CW-1:0] to_cnt;
  logic          ext, brk;
  logic [7:0]    held;

  // Sync flops reset to the idle-high line level so reset release never
  // fabricates a falling edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= bus.ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= R_IDLE;
      bit_cnt         <= 3'd0;
      shift_reg       <= 8'd0;
      parity          <= 1'b0;
      to_cnt          <= '0;
      bus.key_valid   <= 1'b0;
      bus.frame_error <= 1'b0;
    end else begin
      bus.key_valid   <= 1'b0;
      bus.frame_error <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          R_IDLE: begin
            if (!dat_s2) begin
              state   <= R_DATA;
              bit_cnt <= 3'd0;
            end
          end
          R_DATA: begin
            shift_reg <= {dat_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= R_PARITY;
          end
          R_PARITY: begin
            parity <= dat_s2;
            state  <= R_STOP;
          end
          default: begin
            if (dat_s2 && (^{shift_reg, parity})) bus.key_valid <= 1'b1;
            else                                  bus.frame_error <= 1'b1;
            state <= R_IDLE;
          end
        endcase
      end else if (state != R_IDLE) begin
        if (to_cnt == TO_MAX) begin
          state           <= R_IDLE;
          to_cnt          <= '0;
          bus.frame_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_ONE;
        end
      end
    end
  end

  // shift_reg holds the accepted byte while key_valid is high; the next frame
  // cannot shift in data for at least one more ps2_clk fall.
  // NOTE: output pulses default to 0 at the top of the clocked block, so each
  // branch only states when it fires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.startGame     <= 1'b0;
      bus.userGameInput <= 3'd0;
      ext               <= 1'b0;
      brk               <= 1'b0;
      held              <= 8'd0;
    end else begin
      bus.startGame     <= 1'b0;
      bus.userGameInput <= 3'd0;
      if (bus.frame_error) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (bus.key_valid) begin
        if (shift_reg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk <= 1'b1;
        end else if (ext) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else if (brk) begin
          brk <= 1'b0;
          if (shift_reg == held) held <= 8'd0;
        end else if (shift_reg != held) begin
          held <= shift_reg;
          case (shift_reg)
            8'h15:        bus.userGameInput <= 3'd1;
            8'h1D:        bus.userGameInput <= 3'd2;
            8'h24:        bus.userGameInput <= 3'd3;
            8'h2D:        bus.userGameInput <= 3'd4;
            8'h2C:        bus.userGameInput <= 3'd5;
            8'h29, 8'h5A: bus.startGame     <= 1'b1;
            default:      ;
          endcase
        end
      end
    end
  end

endmodule
